// File: rtl/trail_map.sv
// Trail map: 112x112 cell store of 3-bit trail codes, per-frame collision check
// for both bikes, and a 1-cycle-latency pixel read port for the colour mapper.
module trail_map #(
    parameter int GRID   = 112,
    parameter int OFFSET = 14,
    parameter int ADDR_W = 14
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [2:0] Game_State,
    input  logic [7:0] Blue_X,
    input  logic [7:0] Blue_Y,
    input  logic [7:0] Red_X,
    input  logic [7:0] Red_Y,
    input  logic [2:0] write_b,
    input  logic [2:0] write_r,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [2:0] trail_code,
    output logic       collision_blue,
    output logic       collision_red,
    output logic       clear_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RD_B  = 3'd2;
    localparam logic [2:0] ST_RD_R  = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_WR_B  = 3'd5;
    localparam logic [2:0] ST_WR_R  = 3'd6;

    localparam int              CELLS     = GRID * GRID;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [9:0]      OFF10     = 10'(OFFSET);
    localparam logic [9:0]      SPAN10    = 10'(4 * GRID);
    localparam logic [7:0]      GRID8     = 8'(GRID);

    // Row-major cell address; only meaningful for on-grid coordinates.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
        cell_addr = ADDR_W'(y) * ADDR_W'(GRID) + ADDR_W'(x);
    endfunction

    function automatic logic on_grid(input logic [7:0] x, input logic [7:0] y);
        on_grid = (x < GRID8) && (y < GRID8);
    endfunction

    logic [2:0]        mem_r [0:CELLS-1];
    logic [2:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              arm_r;
    logic              fc_meta_r, fc_sync_r, fc_prev_r, frame_edge_s;
    logic [7:0]        bx_r, by_r, rx_r, ry_r;
    logic [2:0]        wb_r, wr_r;
    logic [2:0]        q_a_r, blue_code_r;
    logic              b_oob_s, r_oob_s, same_s, hit_b_s, hit_r_s;
    logic              a_we_s, a_re_s;
    logic [ADDR_W-1:0] a_addr_s;
    logic [2:0]        a_wdata_s;
    logic              collision_blue_r, collision_red_r, clear_busy_r;
    logic [9:0]        dx_off_s, dy_off_s;
    logic              pix_in_s, pix_in_r;
    logic [ADDR_W-1:0] pix_addr_s;
    logic [2:0]        pix_q_r;

    assign frame_edge_s = fc_sync_r & ~fc_prev_r;
    assign b_oob_s      = ~on_grid(bx_r, by_r);
    assign r_oob_s      = ~on_grid(rx_r, ry_r);
    assign same_s       = (bx_r == rx_r) && (by_r == ry_r);
    // q_a_r holds the red cell during CHK; the blue cell was parked in blue_code_r.
    assign hit_b_s      = b_oob_s | (blue_code_r != 3'd0) | same_s;
    assign hit_r_s      = r_oob_s | (q_a_r != 3'd0) | same_s;

    // Off-play-area pixels wrap to large offsets, so one unsigned compare covers both sides.
    assign dx_off_s   = DrawX - OFF10;
    assign dy_off_s   = DrawY - OFF10;
    assign pix_in_s   = (dx_off_s < SPAN10) && (dy_off_s < SPAN10);
    assign pix_addr_s = pix_in_s ? cell_addr(dx_off_s[9:2], dy_off_s[9:2]) : {ADDR_W{1'b0}};

    // Next-state logic for the clear/update sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((Game_State == 3'b001) && arm_r) begin
                    state_nxt_s = ST_CLEAR;
                end else if (frame_edge_s && (Game_State == 3'b010)) begin
                    state_nxt_s = ST_RD_B;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RD_B: state_nxt_s = ST_RD_R;
            ST_RD_R: state_nxt_s = ST_CHK;
            ST_CHK:  state_nxt_s = ST_WR_B;
            ST_WR_B: state_nxt_s = ST_WR_R;
            ST_WR_R: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // Port A control; the blue read uses live inputs since they are captured on the same edge.
    always_comb begin
        a_we_s    = 1'b0;
        a_re_s    = 1'b0;
        a_addr_s  = {ADDR_W{1'b0}};
        a_wdata_s = 3'd0;
        case (state_r)
            ST_CLEAR: begin
                a_we_s   = 1'b1;
                a_addr_s = clr_addr_r;
            end
            ST_RD_B: begin
                a_re_s   = on_grid(Blue_X, Blue_Y);
                a_addr_s = cell_addr(Blue_X, Blue_Y);
            end
            ST_RD_R: begin
                a_re_s   = ~r_oob_s;
                a_addr_s = cell_addr(rx_r, ry_r);
            end
            ST_WR_B: begin
                a_we_s    = ~b_oob_s && (wb_r != 3'd0);
                a_addr_s  = cell_addr(bx_r, by_r);
                a_wdata_s = wb_r;
            end
            ST_WR_R: begin
                a_we_s    = ~r_oob_s && (wr_r != 3'd0);
                a_addr_s  = cell_addr(rx_r, ry_r);
                a_wdata_s = wr_r;
            end
            default: begin
                a_we_s = 1'b0;
                a_re_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, clear address and the clear re-arm latch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_CLEAR;
            clr_addr_r   <= {ADDR_W{1'b0}};
            arm_r        <= 1'b0;
            clear_busy_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            clear_busy_r <= (state_nxt_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_addr_r + ADDR_W'(1);
                arm_r      <= 1'b0;
            end else begin
                clr_addr_r <= {ADDR_W{1'b0}};
                arm_r      <= arm_r | (Game_State != 3'b001);
            end
        end
    end

    // frame_clk synchronizer and edge history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_meta_r <= 1'b0;
            fc_sync_r <= 1'b0;
            fc_prev_r <= 1'b0;
        end else begin
            fc_meta_r <= frame_clk;
            fc_sync_r <= fc_meta_r;
            fc_prev_r <= fc_sync_r;
        end
    end

    // Per-update operand capture: coordinates/codes in RD_B, blue cell data in RD_R.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bx_r        <= 8'd0;
            by_r        <= 8'd0;
            rx_r        <= 8'd0;
            ry_r        <= 8'd0;
            wb_r        <= 3'd0;
            wr_r        <= 3'd0;
            blue_code_r <= 3'd0;
        end else begin
            if (state_r == ST_RD_B) begin
                bx_r <= Blue_X;
                by_r <= Blue_Y;
                rx_r <= Red_X;
                ry_r <= Red_Y;
                wb_r <= write_b;
                wr_r <= write_r;
            end
            if (state_r == ST_RD_R) begin
                blue_code_r <= q_a_r;
            end
        end
    end

    // Sticky collision flags, cleared only by a map clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            collision_blue_r <= 1'b0;
            collision_red_r  <= 1'b0;
        end else if (state_r == ST_CLEAR) begin
            collision_blue_r <= 1'b0;
            collision_red_r  <= 1'b0;
        end else if (state_r == ST_CHK) begin
            collision_blue_r <= collision_blue_r | hit_b_s;
            collision_red_r  <= collision_red_r | hit_r_s;
        end
    end

    // Port A: read-first single port owned by the sequencer.
    always_ff @(posedge Clk) begin
        if (a_we_s) begin
            mem_r[a_addr_s] <= a_wdata_s;
        end
        if (a_re_s) begin
            q_a_r <= mem_r[a_addr_s];
        end
    end

    // Port B: renderer read, always one cycle.
    always_ff @(posedge Clk) begin
        pix_q_r <= mem_r[pix_addr_s];
    end

    // Registered in-play-area flag qualifies the port B data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_in_r <= 1'b0;
        end else begin
            pix_in_r <= pix_in_s;
        end
    end

    assign trail_code     = pix_in_r ? pix_q_r : 3'd0;
    assign collision_blue = collision_blue_r;
    assign collision_red  = collision_red_r;
    assign clear_busy     = clear_busy_r;

endmodule

// File: tb/tb_trail_map.sv
// Bench for trail_map: directed trail/collision sequences, a render-port vector
// table, and randomized frames checked against an array model of the map.
module tb_trail_map;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [2:0] Game_State = 3'b010;
    logic [7:0] Blue_X = 8'd0, Blue_Y = 8'd0, Red_X = 8'd0, Red_Y = 8'd0;
    logic [2:0] write_b = 3'd0, write_r = 3'd0;
    logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
    logic [2:0] trail_code;
    logic       collision_blue, collision_red, clear_busy;

    trail_map dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Game_State(Game_State),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .write_b(write_b), .write_r(write_r), .DrawX(DrawX), .DrawY(DrawY),
        .trail_code(trail_code), .collision_blue(collision_blue),
        .collision_red(collision_red), .clear_busy(clear_busy)
    );

    always #10 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int map_m [12544];
    bit mb = 1'b0;
    bit mr = 1'b0;

    typedef struct { int dx; int dy; int exp; } rvec_t;
    rvec_t rv [18];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        foreach (map_m[i]) map_m[i] = 0;
        mb = 1'b0;
        mr = 1'b0;
    endfunction

    // One frame of the game rules: collisions look at the map before this frame's writes.
    function automatic void model_frame(input int bx, by, rx, ry, wb, wr);
        bit bo = (bx >= 112) || (by >= 112);
        bit ro = (rx >= 112) || (ry >= 112);
        bit same = (bx == rx) && (by == ry);
        if (bo || same || map_m[by * 112 + bx] != 0) mb = 1'b1;
        if (ro || same || map_m[ry * 112 + rx] != 0) mr = 1'b1;
        if (!bo && wb != 0) map_m[by * 112 + bx] = wb;
        if (!ro && wr != 0) map_m[ry * 112 + rx] = wr;
    endfunction

    function automatic int exp_pix(input int dx, dy);
        if (dx < 14 || dx >= 462 || dy < 14 || dy >= 462) return 0;
        return map_m[((dy - 14) / 4) * 112 + (dx - 14) / 4];
    endfunction

    function automatic int rnd_coord();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(112, 255));
        return int'($urandom_range(0, 11));
    endfunction

    task automatic read_px(input int dx, dy, exp, input string name);
        @(negedge Clk);
        DrawX = dx[9:0];
        DrawY = dy[9:0];
        @(posedge Clk);
        #1;
        chk(name, {29'd0, trail_code}, exp);
    endtask

    task automatic read_rand();
        int x = int'($urandom_range(0, 11));
        int y = int'($urandom_range(0, 11));
        int dx = 14 + 4 * x + int'($urandom_range(0, 3));
        int dy = 14 + 4 * y + int'($urandom_range(0, 3));
        read_px(dx, dy, exp_pix(dx, dy), "rand_cell");
        dx = int'($urandom_range(0, 1023));
        dy = int'($urandom_range(0, 1023));
        read_px(dx, dy, exp_pix(dx, dy), "rand_pix");
    endtask

    // Frame edge raised before P1: flags land on the 6th edge, red write on the 8th.
    task automatic frame(input int bx, by, rx, ry, wb, wr);
        @(negedge Clk);
        Blue_X = bx[7:0]; Blue_Y = by[7:0]; Red_X = rx[7:0]; Red_Y = ry[7:0];
        write_b = wb[2:0]; write_r = wr[2:0];
        frame_clk = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        chk("flag_b_pre", {31'd0, collision_blue}, {31'd0, mb});
        chk("flag_r_pre", {31'd0, collision_red}, {31'd0, mr});
        Blue_X = 8'($urandom); Blue_Y = 8'($urandom); Red_X = 8'($urandom); Red_Y = 8'($urandom);
        write_b = 3'($urandom); write_r = 3'($urandom);
        model_frame(bx, by, rx, ry, wb, wr);
        @(negedge Clk);
        chk("flag_b", {31'd0, collision_blue}, {31'd0, mb});
        chk("flag_r", {31'd0, collision_red}, {31'd0, mr});
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Counts busy cycles; a frame request mid-clear must be dropped.
    task automatic wait_clear(input bit hold);
        int cnt = 0;
        while (clear_busy === 1'b1 && cnt < 20000) begin
            @(posedge Clk);
            #1;
            cnt++;
            if (cnt == 100) begin
                chk("flags_in_clear", {30'd0, collision_blue, collision_red}, 32'd0);
                Blue_X = 8'd20; Blue_Y = 8'd20; Red_X = 8'd21; Red_Y = 8'd20;
                write_b = 3'd1; write_r = 3'd2;
                frame_clk = 1'b1;
            end
            if (cnt == 110) frame_clk = 1'b0;
            if (cnt == 200 && !hold) Game_State = 3'b010;
        end
        chk("clear_len", cnt, 32'd12544);
        if (hold) begin
            repeat (3) begin
                @(posedge Clk);
                #1;
                chk("no_retrigger", {31'd0, clear_busy}, 32'd0);
            end
            Game_State = 3'b010;
        end
        read_px(14 + 80, 14 + 80, 0, "dropped_frame_cell");
    endtask

    task automatic game_clear(input bit hold);
        @(negedge Clk);
        Game_State = 3'b001;
        @(posedge Clk);
        #1;
        chk("clear_enter", {31'd0, clear_busy}, 32'd1);
        model_clear();
        wait_clear(hold);
        chk("flags_after_clear", {30'd0, collision_blue, collision_red}, 32'd0);
    endtask

    task automatic mid_update_reset();
        @(negedge Clk);
        Blue_X = 8'd5; Blue_Y = 8'd5; Red_X = 8'd6; Red_Y = 8'd5; write_b = 3'd1; write_r = 3'd3;
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, clear_busy}, 32'd1);
        chk("abort_flags", {30'd0, collision_blue, collision_red}, 32'd0);
        model_clear();
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        Reset_n = 1'b1;
        wait_clear(1'b0);
        read_px(14 + 20, 14 + 20, 0, "abort_no_write_b");
        read_px(14 + 24, 14 + 20, 0, "abort_no_write_r");
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at 3 ms, expected to finish earlier");
        $fatal(1);
    end

    initial begin
        rv[0]  = '{14, 14, 5};    rv[1]  = '{17, 17, 5};    rv[2]  = '{18, 14, 0};
        rv[3]  = '{13, 14, 0};    rv[4]  = '{14, 13, 0};    rv[5]  = '{462, 14, 0};
        rv[6]  = '{461, 461, 4};  rv[7]  = '{458, 458, 4};  rv[8]  = '{457, 457, 0};
        rv[9]  = '{462, 461, 0};  rv[10] = '{461, 462, 0};  rv[11] = '{26, 26, 3};
        rv[12] = '{29, 29, 3};    rv[13] = '{30, 26, 0};    rv[14] = '{1023, 1023, 0};
        rv[15] = '{0, 0, 0};      rv[16] = '{14, 34, 0};    rv[17] = '{14, 38, 0};

        model_clear();
        repeat (3) @(negedge Clk);
        chk("rst_busy", {31'd0, clear_busy}, 32'd1);
        chk("rst_flags", {30'd0, collision_blue, collision_red}, 32'd0);
        chk("rst_code", {29'd0, trail_code}, 32'd0);
        Reset_n = 1'b1;
        wait_clear(1'b0);
        read_px(14, 14, 0, "cleared_cell0");
        read_px(461, 461, 0, "cleared_last");

        frame(10, 10, 100, 100, 1, 3);
        read_px(54, 54, 1, "cell1130");
        read_px(414, 414, 3, "cell_red_100");
        chk("t2_flags", {30'd0, collision_blue, collision_red}, 32'd0);

        frame(11, 10, 10, 10, 1, 3);
        chk("t3_red", {31'd0, collision_red}, 32'd1);
        chk("t3_blue", {31'd0, collision_blue}, 32'd0);
        frame(12, 10, 9, 10, 1, 3);
        chk("t3_red_sticky", {31'd0, collision_red}, 32'd1);

        frame(50, 60, 50, 60, 2, 4);
        chk("t4_both", {30'd0, collision_blue, collision_red}, 32'd3);
        read_px(214, 254, 4, "cell6770");

        game_clear(1'b1);

        frame(112, 5, 3, 3, 1, 3);
        chk("t5_blue", {31'd0, collision_blue}, 32'd1);
        chk("t5_red", {31'd0, collision_red}, 32'd0);
        frame(0, 0, 111, 111, 5, 4);
        foreach (rv[i]) read_px(rv[i].dx, rv[i].dy, rv[i].exp, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            if (i == 20) mid_update_reset();
            frame(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            read_rand();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
